pc_sequencer: RTL and testbench

Fetch-stage PC controller for the 5-stage MIPS pipeline. Owns the PC/nPC register pair and sequences instruction fetch using the branch decision and target from the branch condition handler in ID. Implements the MIPS single delay slot, J/JAL/JR/JALR redirection, hazard-unit stalls and link-address generation. Sits between the ID-stage branch/condition logic and instruction memory.

---
 rtl/mips_pkg.sv | 6 +
 rtl/jump_target_mux.sv | 27 ++
 rtl/pc_sequencer.sv | 84 ++++++++
 tb/tb_pc_sequencer.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared jump-kind codes, fetch FSM states and word size for the fetch stage.
package mips_pkg;
   typedef enum logic [1:0] {JK_COND = 2'b00, JK_ABS = 2'b01, JK_REG = 2'b10, JK_RSVD = 2'b11} jump_kind_e;
   typedef enum logic [1:0] {ST_RST = 2'b00, ST_RUN = 2'b01, ST_SLOT = 2'b10} state_e;
   localparam logic [31:0] WORD_BYTES = 32'd4;
endpackage

// File: rtl/jump_target_mux.sv
// jump_target_mux: decides whether the ID-stage branch/jump is taken and selects its target.
module jump_target_mux
   import mips_pkg::*;
(
   input  logic [1:0]  jump_kind_i,
   input  logic        id_b_instr_i,
   input  logic        branch_taken_i,
   input  logic [31:0] branch_target_i,
   input  logic [25:0] instr_index_i,
   input  logic [31:0] rs_target_i,
   input  logic [31:0] pc_i,
   output logic        taken_o,
   output logic [31:0] target_o,
   output logic        misaligned_o
);
   logic is_cond, is_abs, is_reg;
   always_comb begin
      is_cond      = jump_kind_i == JK_COND;
      is_abs       = jump_kind_i == JK_ABS;
      is_reg       = jump_kind_i == JK_REG;
      taken_o      = id_b_instr_i & ((is_cond & branch_taken_i) | is_abs | is_reg);
      // ABS uses the region bits of the delay slot's address, i.e. the current fetch PC
      target_o     = is_abs ? {pc_i[31:28], instr_index_i, 2'b00} :
                     is_reg ? {rs_target_i[31:2], 2'b00} : branch_target_i;
      misaligned_o = is_reg & (|rs_target_i[1:0]);
   end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage PC/nPC controller with single delay slot, stalls and link address.
module pc_sequencer
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        stall_i,
   input  logic        id_b_instr_i,
   input  logic        branch_taken_i,
   input  logic [1:0]  jump_kind_i,
   input  logic [31:0] branch_target_i,
   input  logic [25:0] instr_index_i,
   input  logic [31:0] rs_target_i,
   input  logic [31:0] id_pc_i,
   output logic [31:0] pc_o,
   output logic [31:0] npc_o,
   output logic        fetch_valid_o,
   output logic        in_slot_o,
   output logic        redirect_o,
   output logic [31:0] link_addr_o,
   output logic        slot_error_o,
   output logic        align_error_o
);
   state_e      state_q;
   logic [31:0] pc_q, npc_q;
   logic        redirect_q, slot_err_q, align_err_q;
   logic        taken, misaligned, redirect_d;
   logic [31:0] target, npc_d;

   jump_target_mux u_mux (
      .jump_kind_i    (jump_kind_i),
      .id_b_instr_i   (id_b_instr_i),
      .branch_taken_i (branch_taken_i),
      .branch_target_i(branch_target_i),
      .instr_index_i  (instr_index_i),
      .rs_target_i    (rs_target_i),
      .pc_i           (pc_q),
      .taken_o        (taken),
      .target_o       (target),
      .misaligned_o   (misaligned)
   );

   always_comb begin
      redirect_d = (state_q == ST_RUN) & taken;
      npc_d      = redirect_d ? target : npc_q + WORD_BYTES;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= ST_RST;
         pc_q        <= RESET_PC;
         npc_q       <= RESET_PC + WORD_BYTES;
         redirect_q  <= 1'b0;
         slot_err_q  <= 1'b0;
         align_err_q <= 1'b0;
      end else if (stall_i) begin
         redirect_q  <= 1'b0;
         slot_err_q  <= 1'b0;
         align_err_q <= 1'b0;
      end else begin
         redirect_q  <= redirect_d;
         align_err_q <= redirect_d & misaligned;
         slot_err_q  <= (state_q == ST_SLOT) & id_b_instr_i;
         if (state_q == ST_RST) begin
            state_q <= ST_RUN;
         end else begin
            pc_q    <= npc_q;
            npc_q   <= npc_d;
            state_q <= redirect_d ? ST_SLOT : ST_RUN;
         end
      end
   end

   assign pc_o          = pc_q;
   assign npc_o         = npc_q;
   assign fetch_valid_o = state_q != ST_RST;
   assign in_slot_o     = state_q == ST_SLOT;
   assign redirect_o    = redirect_q;
   assign slot_error_o  = slot_err_q;
   assign align_error_o = align_err_q;
   assign link_addr_o   = id_pc_i + 2 * WORD_BYTES;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scoreboard bench; a behavioural fetch model predicts every edge.
module tb_pc_sequencer;
   logic        clk = 1'b0;
   logic        reset, stall, id_b_instr, branch_taken;
   logic [1:0]  jump_kind;
   logic [31:0] branch_target, rs_target, id_pc;
   logic [25:0] instr_index;
   logic [31:0] pc, npc, link_addr;
   logic        fetch_valid, in_slot, redirect, slot_error, align_error;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] npc;
      logic        fv;
      logic        slot;
      logic        redir;
      logic        serr;
      logic        aerr;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          failures = 0;
   int          m_state;
   logic [31:0] m_pc, m_npc;

   always #5 clk = ~clk;

   pc_sequencer #(.RESET_PC(32'h0)) dut (
      .clk_i          (clk),
      .reset_i        (reset),
      .stall_i        (stall),
      .id_b_instr_i   (id_b_instr),
      .branch_taken_i (branch_taken),
      .jump_kind_i    (jump_kind),
      .branch_target_i(branch_target),
      .instr_index_i  (instr_index),
      .rs_target_i    (rs_target),
      .id_pc_i        (id_pc),
      .pc_o           (pc),
      .npc_o          (npc),
      .fetch_valid_o  (fetch_valid),
      .in_slot_o      (in_slot),
      .redirect_o     (redirect),
      .link_addr_o    (link_addr),
      .slot_error_o   (slot_error),
      .align_error_o  (align_error)
   );

   task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drives one cycle of inputs, pushes the model's prediction, then checks the DUT after the edge.
   task automatic step(input logic rst, input logic stl, input logic bi, input logic bt,
                       input logic [1:0] kind, input logic [31:0] btgt, input logic [25:0] idx,
                       input logic [31:0] rs, input logic [31:0] idp, input string tag);
      exp_t        e, g;
      logic        tk;
      logic [31:0] tgt;
      reset = rst; stall = stl; id_b_instr = bi; branch_taken = bt; jump_kind = kind;
      branch_target = btgt; instr_index = idx; rs_target = rs; id_pc = idp;
      #1 cmp({tag, "_link"}, link_addr, idp + 32'd8);
      tk  = bi && ((kind == 2'd0 && bt) || kind == 2'd1 || kind == 2'd2);
      tgt = (kind == 2'd1) ? {m_pc[31:28], idx, 2'b00} : (kind == 2'd2) ? {rs[31:2], 2'b00} : btgt;
      e.redir = 1'b0; e.serr = 1'b0; e.aerr = 1'b0;
      if (rst) begin
         m_state = 0; m_pc = 32'h0; m_npc = 32'h4;
      end else if (!stl) begin
         if (m_state == 0) m_state = 1;
         else if (m_state == 1 && tk) begin
            e.redir = 1'b1; e.aerr = (kind == 2'd2) && (rs[1:0] != 2'b00);
            m_pc = m_npc; m_npc = tgt; m_state = 2;
         end else begin
            e.serr = (m_state == 2) && bi;
            m_pc = m_npc; m_npc = m_npc + 32'd4; m_state = 1;
         end
      end
      e.pc = m_pc; e.npc = m_npc; e.fv = m_state != 0; e.slot = m_state == 2;
      sb.push_back(e);
      @(posedge clk);
      #1;
      g = sb.pop_front();
      cmp({tag, "_pc"}, pc, g.pc);
      cmp({tag, "_npc"}, npc, g.npc);
      cmp({tag, "_fv"}, {31'd0, fetch_valid}, {31'd0, g.fv});
      cmp({tag, "_slot"}, {31'd0, in_slot}, {31'd0, g.slot});
      cmp({tag, "_redir"}, {31'd0, redirect}, {31'd0, g.redir});
      cmp({tag, "_serr"}, {31'd0, slot_error}, {31'd0, g.serr});
      cmp({tag, "_aerr"}, {31'd0, align_error}, {31'd0, g.aerr});
   endtask

   task automatic idle(input string tag);
      step(0, 0, 0, 0, 2'd0, 32'h0, 26'h0, 32'h0, 32'h0, tag);
   endtask

   task automatic jr(input logic [31:0] rs, input string tag);
      step(0, 0, 1, 0, 2'd2, 32'h0, 26'h0, rs, 32'h0, tag);
   endtask

   initial begin
      m_state = 0; m_pc = 32'h0; m_npc = 32'h4;
      @(posedge clk); #1;
      step(1, 0, 0, 0, 2'd0, 32'h0, 26'h0, 32'h0, 32'h0, "rst0");
      step(1, 0, 0, 0, 2'd0, 32'h0, 26'h0, 32'h0, 32'h0, "rst1");
      cmp("rst_pc_const", pc, 32'h0);
      cmp("rst_npc_const", npc, 32'h4);
      cmp("rst_fv_const", {31'd0, fetch_valid}, 32'd0);
      idle("rel0");
      cmp("rel_fv_const", {31'd0, fetch_valid}, 32'd1);
      idle("rel1");
      cmp("rel_pc_const", pc, 32'h4);
      for (int i = 0; i < 4; i++) idle("walk");
      cmp("walk_pc_const", pc, 32'h14);
      step(0, 0, 1, 1, 2'd0, 32'h40, 26'h0, 32'h0, 32'h10, "cond");
      cmp("cond_slot_pc_const", pc, 32'h18);
      idle("cond_tgt");
      cmp("cond_pc_const", pc, 32'h40);
      cmp("cond_npc_const", npc, 32'h44);
      step(0, 0, 1, 0, 2'd0, 32'h80, 26'h0, 32'h0, 32'h40, "cond_nt");
      jr(32'h3000_0000, "jr_hi");
      idle("jr_hi_s");
      idle("jr_hi_r0");
      idle("jr_hi_r1");
      cmp("jal_pre_pc_const", pc, 32'h3000_0008);
      step(0, 0, 1, 0, 2'd1, 32'h0, 26'h100, 32'h0, 32'h3000_0004, "jal");
      cmp("jal_npc_const", npc, 32'h3000_0400);
      idle("jal_s");
      jr(32'h0000_0102, "jr_mis");
      cmp("jr_mis_npc_const", npc, 32'h100);
      idle("jr_mis_s");
      jr(32'h200, "stl_jr");
      for (int i = 0; i < 3; i++)
         step(0, 1, 1, 0, 2'd1, 32'h0, 26'h55, 32'h0, 32'h0, "stl_slot");
      step(0, 0, 1, 0, 2'd1, 32'h0, 26'h55, 32'h0, 32'h0, "slot_br");
      step(0, 1, 1, 1, 2'd0, 32'h600, 26'h0, 32'h0, 32'h200, "stl_run0");
      step(0, 1, 1, 1, 2'd0, 32'h600, 26'h0, 32'h0, 32'h200, "stl_run1");
      step(0, 0, 1, 1, 2'd0, 32'h600, 26'h0, 32'h0, 32'h200, "stl_rel");
      idle("stl_rel_s");
      step(0, 0, 1, 1, 2'd3, 32'h900, 26'h3, 32'h904, 32'h600, "rsvd");
      jr(32'hFFFF_FFF8, "wrap_jr");
      idle("wrap_s");
      idle("wrap_r");
      cmp("wrap_pc_const", pc, 32'hFFFF_FFFC);
      cmp("wrap_npc_const", npc, 32'h0);
      idle("wrap_after");
      jr(32'h500, "rs_jr");
      step(1, 1, 1, 0, 2'd2, 32'h0, 26'h0, 32'h700, 32'h0, "rs_slot");
      cmp("rs_pc_const", pc, 32'h0);
      idle("rs_rel0");
      idle("rs_rel1");
      cmp("rs_end_pc_const", pc, 32'h4);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
